multdiv_issue_ctrl: RTL and testbench
=====================================

// Module: multdiv_issue_ctrl
// PURPOSE
// Sequences the iterative multiply/divide unit for the processor pipeline.
// Captures a mul/div issue from decode, launches it to the unit, stalls the
// pipeline on new issues and RAW hazards while busy, then holds a writeback
// request (result, rd, exception) until the register-file port acknowledges.
// PARAMETERS
// TIMEOUT_CYCLES  40  max cycles in BUSY before forcing a timeout exception
// CNT_W           6   width of cycle counter; 2**CNT_W > TIMEOUT_CYCLES
// PORTS
// clock        in   1   system clock, rising edge
// reset        in   1   asynchronous, active-high
// issue_mul    in   1   decode requests a mul this cycle
// issue_div    in   1   decode requests a div this cycle
// issue_rd     in   5   destination register of the issuing op
// issue_opA    in   32  operand A
// issue_opB    in   32  operand B
// rs_addr      in   5   source reg A of the instruction in decode
// rt_addr      in   5   source reg B of the instruction in decode
// md_ctrl_mult out  1   one-cycle start pulse, multiply
// md_ctrl_div  out  1   one-cycle start pulse, divide
// md_opA       out  32  registered operand A, stable from LAUNCH to IDLE
// md_opB       out  32  registered operand B, stable from LAUNCH to IDLE
// md_result    in   32  unit result
// md_exception in   1   unit exception, valid with md_rdy
// md_rdy       in   1   unit result valid
// wb_valid     out  1   writeback request
// wb_rd        out  5   writeback register
// wb_data      out  32  writeback data
// wb_exc       out  1   writeback carries an exception
// wb_ack       in   1   register file accepted writeback
// busy         out  1   state != IDLE
// stall        out  1   freeze fetch/decode
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; captured operands, rd, op and counter 0.
//   Reset mid-operation aborts it; a later md_rdy is ignored in IDLE.
// - IDLE: issue_mul|issue_div captures opA/opB/rd/op -> LAUNCH. Both high:
//   mul wins, div dropped.
// - LAUNCH (1 cycle): md_ctrl_mult or md_ctrl_div high; counter cleared;
//   md_rdy ignored -> BUSY.
// - BUSY: counter +1 per cycle. md_rdy: capture md_result, md_exception ->
//   WB. Counter == TIMEOUT_CYCLES-1 with no md_rdy: result 0, exc 1 -> WB.
//   md_rdy in the same cycle as timeout wins.
// - WB: wb_valid held with stable wb_rd/wb_data/wb_exc until wb_ack, then
//   IDLE next cycle. Captured rd == 0 and exc == 0: WB skipped, BUSY -> IDLE.
// - Issues while busy are ignored; decode must hold them (stall covers it).
// - hazard = busy & pending_rd != 0 & (rs_addr == pending_rd |
//   rt_addr == pending_rd). stall = busy & (issue_mul | issue_div | hazard).
//   Purely combinational; drops the cycle state returns to IDLE.
// - Latency issue -> wb_valid: N+2 cycles, N = unit cycles to md_rdy after
//   the start pulse; minimum occupancy issue -> IDLE is N+3 cycles.
// CONFIGURATION
// - MULTDIV_EXC_WB_EN defined: exception writeback redirected to rd 30
//   (rstatus), wb_data = 4 for mul, 5 for div, wb_exc = 1; hazard also
//   checks r30 while an exception is pending.
// - Undefined: exception writes captured result to captured rd, wb_exc = 1.
// TESTING
// - mul 6*7 rd=3, md_rdy after 32 cycles -> one start pulse, wb_valid rd=3
//   data 42 at cycle 34; ack -> busy 0 next cycle.
// - div, rs_addr=5 with pending rd=5 -> stall 1 until IDLE; rs_addr=6 while
//   busy with no issue -> stall 0.
// - div by zero, md_exception=1 -> with macro wb_rd=30 data 5; without,
//   wb_rd=rd, wb_exc=1.
// - md_rdy never asserted -> timeout at TIMEOUT_CYCLES, wb_exc=1, data 0.
// - issue_mul and issue_div together -> only md_ctrl_mult pulses; rd=0 op
//   with no exception -> no wb_valid, busy clears.
// - reset asserted in BUSY -> all outputs 0 at once; later md_rdy ignored;
//   wb_ack held low 5 cycles -> wb_* stable for 5 cycles.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
// Issue/writeback sequencer for the iterative multiply/divide unit.
// Captures a mul/div issue, pulses the unit start, waits for md_rdy (or a
// timeout), then holds a writeback request until the register file acks.
// Stalls decode on new issues and RAW hazards against the pending rd.
// Optional feature macro: MULTDIV_EXC_WB_EN redirects exception writebacks
// to r30 (rstatus) with a cause code instead of the captured result.
module multdiv_issue_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 40,
   parameter int unsigned CNT_W          = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_mul,
   input  logic        issue_div,
   input  logic [4:0]  issue_rd,
   input  logic [31:0] issue_opA,
   input  logic [31:0] issue_opB,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic        md_ctrl_mult,
   output logic        md_ctrl_div,
   output logic [31:0] md_opA,
   output logic [31:0] md_opB,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_rdy,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exc,
   input  logic        wb_ack,
   output logic        busy,
   output logic        stall
);

   typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StWb} state_e;

   state_e            state_q, state_d;
   logic [31:0]       op_a_q, op_a_d;
   logic [31:0]       op_b_q, op_b_d;
   logic [4:0]        rd_q, rd_d;
   logic              op_div_q, op_div_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       res_q, res_d;
   logic              exc_q, exc_d;

   logic issue;
   logic timeout;
   logic cap_exc;
   logic skip_wb;
   logic hazard;

   assign issue   = issue_mul | issue_div;
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   // Exception flag that will be captured this cycle if BUSY completes.
   assign cap_exc = md_rdy ? md_exception : 1'b1;
   assign skip_wb = (rd_q == 5'd0) & ~cap_exc;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; md_rdy beats the timeout when both occur together.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (issue) state_d = StLaunch;
         StLaunch: state_d = StBusy;
         StBusy: begin
            if (md_rdy || timeout) state_d = skip_wb ? StIdle : StWb;
         end
         StWb:     if (wb_ack) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Datapath registers: operands, destination, op, counter, result.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_a_q   <= '0;
         op_b_q   <= '0;
         rd_q     <= '0;
         op_div_q <= 1'b0;
         cnt_q    <= '0;
         res_q    <= '0;
         exc_q    <= 1'b0;
      end else begin
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         rd_q     <= rd_d;
         op_div_q <= op_div_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         exc_q    <= exc_d;
      end
   end

   // Datapath next-state; captured values only change in IDLE or at BUSY exit.
   always_comb begin
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      rd_d     = rd_q;
      op_div_d = op_div_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      exc_d    = exc_q;
      unique case (state_q)
         StIdle: begin
            if (issue) begin
               op_a_d   = issue_opA;
               op_b_d   = issue_opB;
               rd_d     = issue_rd;
               op_div_d = ~issue_mul;  // mul wins a simultaneous request
               res_d    = '0;
               exc_d    = 1'b0;
            end
         end
         StLaunch: cnt_d = '0;
         StBusy: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (md_rdy) begin
               res_d = md_result;
               exc_d = md_exception;
            end else if (timeout) begin
               res_d = '0;
               exc_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Outputs: start pulses, writeback request, busy and decode stall.
   always_comb begin
      md_ctrl_mult = (state_q == StLaunch) & ~op_div_q;
      md_ctrl_div  = (state_q == StLaunch) & op_div_q;
      md_opA       = op_a_q;
      md_opB       = op_b_q;
      wb_valid     = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      wb_exc       = 1'b0;
      if (state_q == StWb) begin
         wb_valid = 1'b1;
`ifdef MULTDIV_EXC_WB_EN
         if (exc_q) begin
            wb_rd   = 5'd30;
            wb_data = op_div_q ? 32'd5 : 32'd4;
            wb_exc  = 1'b1;
         end else begin
            wb_rd   = rd_q;
            wb_data = res_q;
            wb_exc  = 1'b0;
         end
`else
         wb_rd   = rd_q;
         wb_data = res_q;
         wb_exc  = exc_q;
`endif
      end
      busy   = (state_q != StIdle);
      hazard = busy & (rd_q != 5'd0) & ((rs_addr == rd_q) | (rt_addr == rd_q));
`ifdef MULTDIV_EXC_WB_EN
      // A pending exception writeback targets r30.
      hazard = hazard | (busy & exc_q & ((rs_addr == 5'd30) | (rt_addr == 5'd30)));
`endif
      stall  = busy & (issue | hazard);
   end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed self-checking bench for multdiv_issue_ctrl.
// Cycle 0 is the cycle an issue is driven; inputs change 1 ns after a rising
// edge and outputs are sampled 1 ns later.
module tb_multdiv_issue_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        issue_mul = 1'b0, issue_div = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [31:0] issue_opA = '0, issue_opB = '0;
   logic [4:0]  rs_addr = '0, rt_addr = '0;
   logic        md_ctrl_mult, md_ctrl_div;
   logic [31:0] md_opA, md_opB;
   logic [31:0] md_result = '0;
   logic        md_exception = 1'b0, md_rdy = 1'b0;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_exc;
   logic        wb_ack = 1'b0;
   logic        busy, stall;

   int n_cmp = 0;
   int n_err = 0;

   multdiv_issue_ctrl dut (
      .clock(clock), .reset(reset),
      .issue_mul(issue_mul), .issue_div(issue_div), .issue_rd(issue_rd),
      .issue_opA(issue_opA), .issue_opB(issue_opB),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
      .md_opA(md_opA), .md_opB(md_opB),
      .md_result(md_result), .md_exception(md_exception), .md_rdy(md_rdy),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc),
      .wb_ack(wb_ack), .busy(busy), .stall(stall)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running want finished");
      $fatal(1, "bench time limit");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic mul, input logic div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
      issue_mul = mul; issue_div = div; issue_rd = rd; issue_opA = a; issue_opB = b;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      #1;
      n_cmp++;
      if ({busy, stall, wb_valid, wb_exc, md_ctrl_mult, md_ctrl_div} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 000000",
                  {busy, stall, wb_valid, wb_exc, md_ctrl_mult, md_ctrl_div});
      end
      n_cmp++;
      if ({wb_rd, wb_data, md_opA, md_opB} !== 101'b0) begin
         n_err++;
         $display("FAIL reset_data: got rd=%0d data=%h opA=%h opB=%h want all 0",
                  wb_rd, wb_data, md_opA, md_opB);
      end
      reset = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_mul_latency();
      int pulses = 0;
      int early_wb = 0;
      issue(1, 0, 5'd3, 32'd6, 32'd7);
      tick();
      issue(0, 0, 5'd0, 32'd0, 32'd0);
      for (int c = 1; c <= 33; c++) begin
         if (c == 33) begin md_rdy = 1'b1; md_result = 32'd42; end
         #1;
         if (md_ctrl_mult === 1'b1) pulses++;
         if (wb_valid !== 1'b0) early_wb++;
         if (c < 33) tick();
      end
      n_cmp++;
      if (pulses != 1) begin
         n_err++; $display("FAIL mul_pulse_count: got %0d want 1", pulses);
      end
      n_cmp++;
      if (early_wb != 0) begin
         n_err++; $display("FAIL mul_early_wb: got %0d cycles want 0", early_wb);
      end
      n_cmp++;
      if (md_opA !== 32'd6 || md_opB !== 32'd7) begin
         n_err++; $display("FAIL mul_operands: got %0d,%0d want 6,7", md_opA, md_opB);
      end
      tick();  // cycle 34
      md_rdy = 1'b0; md_result = '0;
      #1;
      n_cmp++;
      if ({wb_valid, wb_rd, wb_data, wb_exc} !== {1'b1, 5'd3, 32'd42, 1'b0}) begin
         n_err++;
         $display("FAIL mul_wb: got v=%b rd=%0d data=%0d exc=%b want v=1 rd=3 data=42 exc=0",
                  wb_valid, wb_rd, wb_data, wb_exc);
      end
      wb_ack = 1'b1;
      tick();  // cycle 35
      wb_ack = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || wb_valid !== 1'b0) begin
         n_err++; $display("FAIL mul_ack_idle: got busy=%b wb_valid=%b want 0 0", busy, wb_valid);
      end
   endtask

   task automatic test_hazard();
      issue(0, 1, 5'd5, 32'd100, 32'd7);
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin
         n_err++; $display("FAIL hz_idle_issue_stall: got %b want 0", stall);
      end
      tick();  // cycle 1, LAUNCH
      issue(0, 0, 5'd0, 32'd0, 32'd0);
      rs_addr = 5'd5;
      #1;
      n_cmp++;
      if (md_ctrl_div !== 1'b1 || md_ctrl_mult !== 1'b0) begin
         n_err++; $display("FAIL hz_div_pulse: got div=%b mult=%b want 1 0", md_ctrl_div, md_ctrl_mult);
      end
      n_cmp++;
      if (stall !== 1'b1) begin
         n_err++; $display("FAIL hz_rs_match: got %b want 1", stall);
      end
      tick();  // cycle 2
      rs_addr = 5'd6;
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin
         n_err++; $display("FAIL hz_no_match: got %b want 0", stall);
      end
      rt_addr = 5'd5;
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_err++; $display("FAIL hz_rt_match: got %b want 1", stall);
      end
      rt_addr = 5'd0;
      issue_mul = 1'b1;
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_err++; $display("FAIL hz_issue_busy: got %b want 1", stall);
      end
      tick();  // cycle 3
      issue_mul = 1'b0;
      rs_addr = 5'd5;
      md_rdy = 1'b1; md_result = 32'd14;
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_err++; $display("FAIL hz_busy_stall: got %b want 1", stall);
      end
      tick();  // cycle 4, WB
      md_rdy = 1'b0; md_result = '0;
      #1;
      n_cmp++;
      if ({wb_valid, wb_rd, wb_data, stall} !== {1'b1, 5'd5, 32'd14, 1'b1}) begin
         n_err++;
         $display("FAIL hz_wb: got v=%b rd=%0d data=%0d stall=%b want v=1 rd=5 data=14 stall=1",
                  wb_valid, wb_rd, wb_data, stall);
      end
      wb_ack = 1'b1;
      tick();  // cycle 5, IDLE
      wb_ack = 1'b0;
      #1;
      n_cmp++;
      if (stall !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL hz_idle_drop: got stall=%b busy=%b want 0 0", stall, busy);
      end
      tick();
      #1;
      n_cmp++;
      if (md_ctrl_mult !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL hz_busy_issue_ignored: got mult=%b busy=%b want 0 0",
                           md_ctrl_mult, busy);
      end
      rs_addr = 5'd0;
   endtask

   task automatic test_div_exc();
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      logic        exp_stall30;
`ifdef MULTDIV_EXC_WB_EN
      exp_rd = 5'd30; exp_data = 32'd5; exp_stall30 = 1'b1;
`else
      exp_rd = 5'd9; exp_data = 32'hFFFF_FFFF; exp_stall30 = 1'b0;
`endif
      issue(0, 1, 5'd9, 32'd50, 32'd0);
      tick();
      issue(0, 0, 5'd0, 32'd0, 32'd0);
      tick();  // cycle 2
      md_rdy = 1'b1; md_exception = 1'b1; md_result = 32'hFFFF_FFFF;
      tick();  // cycle 3, WB
      md_rdy = 1'b0; md_exception = 1'b0; md_result = '0;
      rs_addr = 5'd30;
      #1;
      n_cmp++;
      if ({wb_valid, wb_rd, wb_data, wb_exc} !== {1'b1, exp_rd, exp_data, 1'b1}) begin
         n_err++;
         $display("FAIL dz_wb: got v=%b rd=%0d data=%h exc=%b want v=1 rd=%0d data=%h exc=1",
                  wb_valid, wb_rd, wb_data, wb_exc, exp_rd, exp_data);
      end
      n_cmp++;
      if (stall !== exp_stall30) begin
         n_err++; $display("FAIL dz_r30_hazard: got %b want %b", stall, exp_stall30);
      end
      rs_addr = 5'd0;
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL dz_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_timeout(input bit rdy_at_limit);
      int early_wb = 0;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      logic        exp_exc;
      if (rdy_at_limit) begin
         exp_rd = 5'd7; exp_data = 32'd77; exp_exc = 1'b0;
      end else begin
`ifdef MULTDIV_EXC_WB_EN
         exp_rd = 5'd30; exp_data = 32'd4; exp_exc = 1'b1;
`else
         exp_rd = 5'd7; exp_data = 32'd0; exp_exc = 1'b1;
`endif
      end
      issue(1, 0, 5'd7, 32'd3, 32'd4);
      tick();
      issue(0, 0, 5'd0, 32'd0, 32'd0);
      // md_rdy at cycle 41 is the same cycle the timeout fires.
      for (int c = 1; c <= 41; c++) begin
         if (rdy_at_limit && c == 41) begin md_rdy = 1'b1; md_result = 32'd77; end
         #1;
         if (wb_valid !== 1'b0) early_wb++;
         if (c < 41) tick();
      end
      n_cmp++;
      if (early_wb != 0) begin
         n_err++; $display("FAIL to_early_wb[%0d]: got %0d cycles want 0", rdy_at_limit, early_wb);
      end
      tick();  // cycle 42
      md_rdy = 1'b0; md_result = '0;
      #1;
      n_cmp++;
      if ({wb_valid, wb_rd, wb_data, wb_exc} !== {1'b1, exp_rd, exp_data, exp_exc}) begin
         n_err++;
         $display("FAIL to_wb[%0d]: got v=%b rd=%0d data=%0d exc=%b want v=1 rd=%0d data=%0d exc=%b",
                  rdy_at_limit, wb_valid, wb_rd, wb_data, wb_exc, exp_rd, exp_data, exp_exc);
      end
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
   endtask

   task automatic test_dual_issue_rd0();
      issue(1, 1, 5'd0, 32'd1, 32'd2);
      tick();  // cycle 1
      issue(0, 0, 5'd0, 32'd0, 32'd0);
      #1;
      n_cmp++;
      if (md_ctrl_mult !== 1'b1 || md_ctrl_div !== 1'b0) begin
         n_err++; $display("FAIL dual_pulse: got mult=%b div=%b want 1 0", md_ctrl_mult, md_ctrl_div);
      end
      tick();  // cycle 2
      md_rdy = 1'b1; md_result = 32'd99;
      #1;
      n_cmp++;
      if (md_ctrl_mult !== 1'b0 || stall !== 1'b0) begin
         n_err++; $display("FAIL dual_busy: got mult=%b stall=%b want 0 0", md_ctrl_mult, stall);
      end
      tick();  // cycle 3
      md_rdy = 1'b0; md_result = '0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || wb_valid !== 1'b0) begin
         n_err++; $display("FAIL rd0_skip_wb: got busy=%b wb_valid=%b want 0 0", busy, wb_valid);
      end
   endtask

   task automatic test_wb_hold();
      int unstable = 0;
      issue(0, 1, 5'd12, 32'hDEAD, 32'd3);
      tick();
      issue(0, 0, 5'd0, 32'd0, 32'd0);
      tick();  // cycle 2
      md_rdy = 1'b1; md_result = 32'h1234;
      tick();  // cycle 3, WB
      md_rdy = 1'b0; md_result = '0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if ({wb_valid, wb_rd, wb_data, wb_exc, md_opA} !==
             {1'b1, 5'd12, 32'h1234, 1'b0, 32'hDEAD}) unstable++;
         tick();
      end
      n_cmp++;
      if (unstable != 0) begin
         n_err++; $display("FAIL wb_hold_stable: got %0d bad cycles want 0", unstable);
      end
      wb_ack = 1'b1;
      #1;
      n_cmp++;
      if (wb_valid !== 1'b1) begin
         n_err++; $display("FAIL wb_hold_still_valid: got %b want 1", wb_valid);
      end
      tick();
      wb_ack = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL wb_hold_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      issue(1, 0, 5'd4, 32'd11, 32'd13);
      tick();
      issue(0, 0, 5'd0, 32'd0, 32'd0);
      for (int k = 0; k < 4; k++) tick();  // cycle 5, BUSY
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_pre_busy: got %b want 1", busy);
      end
      issue_mul = 1'b1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({busy, stall, wb_valid, md_ctrl_mult, md_opA, md_opB} !== 68'b0) begin
         n_err++;
         $display("FAIL rst_mid_outputs: got busy=%b stall=%b v=%b opA=%0d opB=%0d want all 0",
                  busy, stall, wb_valid, md_opA, md_opB);
      end
      issue_mul = 1'b0;
      #1;
      reset = 1'b0;
      md_rdy = 1'b1; md_result = 32'd55;
      tick();
      md_rdy = 1'b0; md_result = '0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || wb_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_rdy_ignored: got busy=%b wb_valid=%b want 0 0",
                           busy, wb_valid);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0 || wb_valid !== 1'b0 || md_ctrl_mult !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_stay_idle: got busy=%b v=%b mult=%b want 0 0 0",
                           busy, wb_valid, md_ctrl_mult);
      end
   endtask

   initial begin
      test_reset();
      test_mul_latency();
      test_hazard();
      test_div_exc();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_dual_issue_rd0();
      test_wb_hold();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
